// File: rtl/alu_pipe_if.sv
// Operand/result bundle between operand fetch, alu_pipe and register writeback.
// Handshake: a beat moves on a rising edge where valid && ready are both 1;
// the producer holds its payload stable while valid=1 and ready=0.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_rn;
  logic [WIDTH-1:0] in_src2;
  logic [3:0]       in_op;
  logic             in_set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_rd;
  logic             out_wb;
  logic [3:0]       out_flags;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, in_rn, in_src2, in_op, in_set_flags, out_ready,
    input  in_ready, out_valid, out_rd, out_wb, out_flags
  );

  // The ALU itself.
  modport slave (
    input  in_valid, in_rn, in_src2, in_op, in_set_flags, out_ready,
    output in_ready, out_valid, out_rd, out_wb, out_flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with NZCV flag register and a one-entry result register.
// One operation per cycle; carry-consuming ops read the architectural C flag
// as it stands on the accepting edge, so dependent ops chain without stalls.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  logic [WIDTH-1:0] a, b, logic_res, res, rd_q;
  logic [WIDTH:0]   sum;
  logic             cin, is_arith, is_cmp, upd, v_new;
  logic             valid_q, wb_q, accept;
  logic [3:0]       flags_q, flags_next;

  // Single adder: subtraction feeds the inverted subtrahend with a carry-in.
  always_comb begin
    a        = bus.in_rn;
    b        = bus.in_src2;
    cin      = 1'b0;
    is_arith = 1'b1;
    unique case (bus.in_op)
      OP_SUB, OP_CMP: begin b = ~bus.in_src2; cin = 1'b1;       end
      OP_RSB:         begin a = bus.in_src2; b = ~bus.in_rn; cin = 1'b1; end
      OP_ADD, OP_CMN: begin cin = 1'b0;                         end
      OP_ADC:         begin cin = flags_q[1];                   end
      OP_SBC:         begin b = ~bus.in_src2; cin = flags_q[1]; end
      OP_RSC:         begin a = bus.in_src2; b = ~bus.in_rn; cin = flags_q[1]; end
      default:        begin is_arith = 1'b0;                    end
    endcase
    sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    v_new = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Logical/move results, final result select and next flag value.
  always_comb begin
    logic_res = '0;
    unique case (bus.in_op)
      OP_AND, OP_TST: logic_res = bus.in_rn & bus.in_src2;
      OP_EOR, OP_TEQ: logic_res = bus.in_rn ^ bus.in_src2;
      OP_ORR:         logic_res = bus.in_rn | bus.in_src2;
      OP_MOV:         logic_res = bus.in_src2;
      OP_BIC:         logic_res = bus.in_rn & ~bus.in_src2;
      OP_MVN:         logic_res = ~bus.in_rn;
      default:        logic_res = '0;
    endcase
    res        = is_arith ? sum[WIDTH-1:0] : logic_res;
    is_cmp     = (bus.in_op[3:2] == 2'b10);
    upd        = bus.in_set_flags || is_cmp;
    flags_next = flags_q;
    if (upd) begin
      // N and Z come from the computed value, before compare/test zeroing.
      flags_next = {res[WIDTH-1], (res == '0),
                    is_arith ? sum[WIDTH] : flags_q[1],
                    is_arith ? v_new      : flags_q[0]};
    end
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Result register and flag register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      flags_q <= 4'b0000;
    end else if (accept) begin
      valid_q <= 1'b1;
      rd_q    <= is_cmp ? '0 : res;
      wb_q    <= !is_cmp;
      flags_q <= flags_next;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_wb    = wb_q;
  assign bus.out_flags = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 32-bit instance driven by directed and random steps
// against a signed/unsigned arithmetic reference, plus a small 8-bit instance.
module tb_alu_pipe;
  typedef struct packed {
    logic [31:0] rd;
    logic        wb;
    logic [3:0]  flags;
  } res_t;

  localparam logic [3:0] AND_ = 4'h0, EOR_ = 4'h1, SUB_ = 4'h2, RSB_ = 4'h3;
  localparam logic [3:0] ADD_ = 4'h4, ADC_ = 4'h5, SBC_ = 4'h6, CMP_ = 4'hA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32, rst8;

  alu_pipe_if #(.WIDTH(32)) bus32 ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(bus32));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q[$];      // {wb, rd} of results not yet consumed
  logic        m_valid;
  logic [3:0]  m_flags;
  logic [3:0]  f8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned magnitude for C, signed range for V, plain ops otherwise.
  function automatic res_t ref_op(input int w, input logic [3:0] op,
                                  input longint unsigned rn, input longint unsigned src2,
                                  input logic s, input logic [3:0] f);
    longint unsigned mask, x, y, val;
    longint          half, sx, sy, sv, kk;
    logic            arith, sub, nc, nv, cmp;
    res_t            r;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(1) << (w - 1);
    x = rn; y = src2; val = 0; kk = 0; arith = 1'b1; sub = 1'b0;
    nc = f[1]; nv = f[0];
    case (op)
      4'h2, 4'hA: begin sub = 1'b1; end
      4'h3:       begin sub = 1'b1; x = src2; y = rn; end
      4'h4, 4'hB: begin sub = 1'b0; end
      4'h5:       begin kk = f[1] ? 1 : 0; end
      4'h6:       begin sub = 1'b1; kk = f[1] ? 0 : 1; end
      4'h7:       begin sub = 1'b1; x = src2; y = rn; kk = f[1] ? 0 : 1; end
      4'h0, 4'h8: begin arith = 1'b0; val = rn & src2; end
      4'h1, 4'h9: begin arith = 1'b0; val = rn ^ src2; end
      4'hC:       begin arith = 1'b0; val = rn | src2; end
      4'hD:       begin arith = 1'b0; val = src2; end
      4'hE:       begin arith = 1'b0; val = rn & ~src2 & mask; end
      default:    begin arith = 1'b0; val = ~rn & mask; end
    endcase
    if (arith) begin
      sx = (x >= longint'(half)) ? longint'(x) - 2 * half : longint'(x);
      sy = (y >= longint'(half)) ? longint'(y) - 2 * half : longint'(y);
      if (sub) begin
        val = (x - y - longint'(kk)) & mask;
        nc  = (x >= y + longint'(kk));      // no borrow
        sv  = sx - sy - kk;
      end else begin
        val = (x + y + longint'(kk)) & mask;
        nc  = ((x + y + longint'(kk)) > mask);
        sv  = sx + sy + kk;
      end
      nv = (sv < -half) || (sv >= half);
    end
    cmp     = (op[3:2] == 2'b10);
    r.flags = (s || cmp) ? {val[w-1], (val == 0), nc, nv} : f;
    r.rd    = cmp ? 32'd0 : val[31:0];
    r.wb    = !cmp;
    return r;
  endfunction

  // ---------------- driver tasks (32-bit) ----------------
  task automatic drive32(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] src2,
                         input logic s, input logic v);
    bus32.in_op = op; bus32.in_rn = rn; bus32.in_src2 = src2;
    bus32.in_set_flags = s; bus32.in_valid = v;
  endtask

  // One clock: called just after a falling edge with inputs already set.
  task automatic step32(output logic acc);
    logic        exp_rdy, take;
    logic [32:0] front;
    res_t        r;
    r = '0;
    #1;
    exp_rdy = !m_valid || bus32.out_ready;
    chk("in_ready", {63'd0, bus32.in_ready}, {63'd0, exp_rdy});
    if (m_valid && exp_q.size() > 0) begin
      front = exp_q[0];
      chk("out_rd", {32'd0, bus32.out_rd}, {32'd0, front[31:0]});
      chk("out_wb", {63'd0, bus32.out_wb}, {63'd0, front[32]});
    end
    acc  = bus32.in_valid && exp_rdy && !rst32;
    take = m_valid && bus32.out_ready;
    if (acc)
      r = ref_op(32, bus32.in_op, bus32.in_rn, bus32.in_src2, bus32.in_set_flags, m_flags);
    @(posedge clk);
    if (rst32) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_flags = 4'b0000;
    end else begin
      if (take) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({r.wb, r.rd});
        m_flags = r.flags;
      end
      m_valid = acc || (m_valid && !take);
    end
    #1;
    chk("out_valid", {63'd0, bus32.out_valid}, {63'd0, m_valid});
    chk("out_flags", {60'd0, bus32.out_flags}, {60'd0, m_flags});
    @(negedge clk);
  endtask

  task automatic send32(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] src2,
                        input logic s, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    drive32(op, rn, src2, s, 1'b1);
    while (!acc && tries < 8) begin
      step32(acc);
      tries++;
    end
    chk("accept_in_time", {63'd0, acc}, 64'd1);
    bus32.in_valid = 1'b0;
  endtask

  // ---------------- driver task (8-bit, always consumed) ----------------
  task automatic op8(input logic [3:0] op, input logic [7:0] rn, input logic [7:0] src2,
                     input logic s);
    res_t r;
    bus8.in_op = op; bus8.in_rn = rn; bus8.in_src2 = src2;
    bus8.in_set_flags = s; bus8.in_valid = 1'b1;
    r = ref_op(8, op, {56'd0, rn}, {56'd0, src2}, s, f8);
    #1;
    chk("w8_in_ready", {63'd0, bus8.in_ready}, 64'd1);
    @(posedge clk);
    f8 = r.flags;
    #1;
    chk("w8_out_valid", {63'd0, bus8.out_valid}, 64'd1);
    chk("w8_out_rd", {56'd0, bus8.out_rd}, {56'd0, r.rd[7:0]});
    chk("w8_out_wb", {63'd0, bus8.out_wb}, {63'd0, r.wb});
    chk("w8_out_flags", {60'd0, bus8.out_flags}, {60'd0, f8});
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic acc;
    int   tries;
    rst32 = 1'b1; rst8 = 1'b1;
    drive32(4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_op = 4'h0; bus8.in_rn = 8'd0;
    bus8.in_src2 = 8'd0; bus8.in_set_flags = 1'b0; bus8.out_ready = 1'b1;
    m_valid = 1'b0; m_flags = 4'b0000; f8 = 4'b0000;
    @(negedge clk);

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      drive32(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      bus32.out_ready = 1'($urandom_range(0, 1));
      step32(acc);
    end
    chk("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("rst_out_rd", {32'd0, bus32.out_rd}, 64'd0);
    chk("rst_out_wb", {63'd0, bus32.out_wb}, 64'd0);
    chk("rst_flags", {60'd0, bus32.out_flags}, 64'd0);
    chk("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    rst32 = 1'b0;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;

    // 64-bit carry chain.
    send32(ADD_, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, tries);
    chk("chain_add_rd", {32'd0, bus32.out_rd}, 64'd0);
    chk("chain_add_flags", {60'd0, bus32.out_flags}, 64'b0110);
    send32(ADC_, 32'd0, 32'd0, 1'b1, tries);
    chk("chain_adc_rd", {32'd0, bus32.out_rd}, 64'd1);
    chk("chain_adc_flags", {60'd0, bus32.out_flags}, 64'b0000);

    // Subtract and compare flags.
    send32(SUB_, 32'd5, 32'd5, 1'b1, tries);
    chk("sub_flags", {60'd0, bus32.out_flags}, 64'b0110);
    send32(CMP_, 32'h8000_0000, 32'd1, 1'b0, tries);
    chk("cmp_rd", {32'd0, bus32.out_rd}, 64'd0);
    chk("cmp_wb", {63'd0, bus32.out_wb}, 64'd0);
    chk("cmp_flags", {60'd0, bus32.out_flags}, 64'b0011);

    // Logical op keeps C and V.
    send32(EOR_, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b1, tries);
    chk("eor_rd", {32'd0, bus32.out_rd}, 64'd0);
    chk("eor_wb", {63'd0, bus32.out_wb}, 64'd1);
    chk("eor_flags", {60'd0, bus32.out_flags}, 64'b0111);

    // Back-pressure: consumer stalls for two cycles after the first ADD.
    send32(ADD_, 32'd1, 32'd1, 1'b0, tries);
    bus32.out_ready = 1'b0;
    drive32(ADD_, 32'd2, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step32(acc);
      chk("bp_stalled", {63'd0, acc}, 64'd0);
      chk("bp_held_rd", {32'd0, bus32.out_rd}, 64'd2);
    end
    bus32.out_ready = 1'b1;
    send32(ADD_, 32'd2, 32'd2, 1'b0, tries);
    chk("bp_second_rd", {32'd0, bus32.out_rd}, 64'd4);
    send32(ADD_, 32'd3, 32'd3, 1'b0, tries);
    chk("bp_third_rd", {32'd0, bus32.out_rd}, 64'd6);
    step32(acc);

    // Full throughput: every op accepted on its first cycle.
    for (int i = 0; i < 20; i++) begin
      send32(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)), tries);
      chk("tput_first_try", 64'(tries), 64'd1);
    end

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      drive32(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      bus32.out_ready = 1'($urandom_range(0, 3) != 0);
      step32(acc);
    end
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;

    // Reset while a result is stalled, with a new op also presented.
    send32(ADD_, 32'd9, 32'd9, 1'b1, tries);
    bus32.out_ready = 1'b0;
    drive32(ADD_, 32'd4, 32'd4, 1'b1, 1'b1);
    rst32 = 1'b1;
    step32(acc);
    chk("midrst_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("midrst_rd", {32'd0, bus32.out_rd}, 64'd0);
    chk("midrst_flags", {60'd0, bus32.out_flags}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    rst32 = 1'b0;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    step32(acc);

    // WIDTH=8 instance.
    rst8 = 1'b0;
    chk("w8_rst_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("w8_rst_flags", {60'd0, bus8.out_flags}, 64'd0);
    op8(SBC_, 8'h00, 8'h00, 1'b1);
    chk("w8_sbc_rd", {56'd0, bus8.out_rd}, 64'hFF);
    chk("w8_sbc_flags", {60'd0, bus8.out_flags}, 64'b1000);
    op8(ADD_, 8'h7F, 8'h01, 1'b1);
    chk("w8_add_flags", {60'd0, bus8.out_flags}, 64'b1001);
    op8(RSB_, 8'h10, 8'h05, 1'b1);
    chk("w8_rsb_rd", {56'd0, bus8.out_rd}, 64'hF5);
    op8(AND_, 8'hA5, 8'h0F, 1'b0);
    for (int i = 0; i < 30; i++)
      op8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the datapath's combinational ALU. Accepts one operation per cycle through a valid/ready handshake, computes it over `WIDTH` bits, and returns the result through a one-entry output register with back-pressure. It holds an architectural NZCV flag register, so add/subtract-with-carry use the true stored carry. Compare/test operations update flags without producing a writeback. It sits between operand fetch and register writeback in the pipelined core.

## Interface
- `WIDTH`, default 32, operand and result width (≥ 4).
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept; `in_ready = !out_valid || out_ready`, combinational.
- `in_rn` in WIDTH: first operand.
- `in_src2` in WIDTH: second operand.
- `in_op` in 4: operation code, encoding in Operation.
- `in_set_flags` in 1: update flags (ignored for codes 1000–1011, which always update).
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: consumer takes result.
- `out_rd` out WIDTH: result (0 for compare/test codes).
- `out_wb` out 1: result is to be written back; 0 for codes 1000–1011.
- `out_flags` out 4: {N,Z,C,V} flag register, always current.

## Operation
- Transfer on an input handshake when `in_valid && in_ready`. On that edge:
  - the result is computed from the current flag register;
  - the result is loaded into the output register and `out_valid` is set to 1;
  - the flag register is updated if selected.
- Output handshake completes when `out_valid && out_ready`. With no new input transfer on the same edge, `out_valid` clears. Simultaneous input and output transfers reload the register and keep `out_valid` at 1 (full throughput).
- Op codes:
  - 0000 AND
  - 0001 EOR
  - 0010 SUB `rn-src2`
  - 0011 RSB `src2-rn`
  - 0100 ADD
  - 0101 ADC `rn+src2+C`
  - 0110 SBC `rn-src2-!C`
  - 0111 RSC `src2-rn-!C`
  - 1000 TST (AND)
  - 1001 TEQ (EOR)
  - 1010 CMP (SUB)
  - 1011 CMN (ADD)
  - 1100 ORR
  - 1101 MOV `src2`
  - 1110 BIC `rn & ~src2`
  - 1111 MVN `~rn`
- Arithmetic width rules: all arithmetic is computed as a `WIDTH+1`-bit sum `a + b + cin`.
  - Subtraction is `a + ~b + cin`, with cin = 1 for SUB/RSB/CMP and cin = C for SBC/RSC.
  - C is bit `WIDTH` of that sum. For subtraction, C = NOT borrow (C=1 means no borrow).
  - V = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' is the inverted or plain second addend actually used.
- Flag update (when enabled):
  - N = result[W-1]; Z = (result == 0). Both are taken from the computed value before the compare/test zeroing.
  - Arithmetic codes (0010–0111, 1010, 1011) update C and V.
  - Logical and move codes leave C and V unchanged.
- Compare/test codes force `out_rd = 0` and `out_wb = 0`. All other codes give `out_wb = 1`.
- No input transfer: flag register and output register hold their values.

## Timing
- Latency: 1 cycle. An input accepted at edge k appears on `out_*` after edge k.
- Carry chaining: a flag-setting op accepted at edge k is visible to an ADC/SBC/RSC accepted at edge k+1. Back-to-back dependent ops need no stall.
- Back-pressure: while `out_valid=1 && out_ready=0`:
  - `in_ready=0`;
  - output register and flags are frozen;
  - input signals are ignored.
- Reset (synchronous, asserted at an edge) gives:
  - `out_valid=0`, `out_rd=0`, `out_wb=0`, flags=0000;
  - `in_ready=1` after the edge.
  - Any held or in-flight result is discarded; there is no partial completion.
- `reset` takes priority over simultaneous handshakes on the same edge.
- `in_ready` and `out_*` are never driven X after reset.

## Test plan
- Reset then idle: hold `reset` 2 cycles with random inputs → `out_valid=0`, `out_rd=0`, `out_flags=0000`, `in_ready=1`.
- 64-bit carry chain (WIDTH=32):
  - ADD S `FFFFFFFF+00000001` → rd 0, flags 0110;
  - next cycle ADC S `00000000+00000000` → rd 1, flags 0000.
- Subtract flags:
  - SUB S `00000005-00000005` → flags 0110 (Z, C=no borrow);
  - CMP `80000000, 00000001` → rd 0, wb 0, flags 0011 (V set, C set).
- Logical preserves C/V: set C=1 V=1 via CMP `80000000,1`, then EOR S `F0F0F0F0^F0F0F0F0` → rd 0, flags 0111.
- Back-pressure: issue 3 ADDs (1+1, 2+2, 3+3) with `out_ready` low for 2 cycles after the first → `in_ready` drops, results 2, 4, 6 arrive in order, none lost or duplicated. Then full throughput (1 per cycle) with `out_ready=1`.
- Reset mid-stall and WIDTH=8 sweep:
  - assert reset while `out_valid=1 && out_ready=0` → valid clears next edge;
  - WIDTH=8 SBC S `00-00` with C=0 → rd FF, flags 1000.
